// File: rtl/fifo_nibble_packer.sv
// Drains 4-bit entries from a sync_fifo read port and packs NIBBLES of them per output word,
// LSB-first, on a valid/ready handshake; flush emits a zero-padded partial word.
module fifo_nibble_packer #(
  parameter int unsigned  DATA_W  = 4,
  parameter int unsigned  NIBBLES = 4,
  localparam int unsigned OUT_W   = DATA_W * NIBBLES,
  localparam int unsigned CNT_W   = $clog2(NIBBLES + 1),
  localparam int unsigned SLOT_W  = $clog2(NIBBLES)
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [OUT_W-1:0]  word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_partial,
  output logic [CNT_W-1:0]  nib_count
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e             r_state, w_state_next;
  logic [OUT_W-1:0]   r_word, w_word_next;
  logic               r_partial, w_partial_next;
  logic [CNT_W-1:0]   r_nib, w_nib_next;
  logic               r_rd_pending, w_rd_pending_next;
  logic               r_flush_req, w_flush_next;
  logic               w_rd_en;
  logic [CNT_W:0]     w_inflight;
  logic [SLOT_W-1:0]  w_slot;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      r_state      <= StFill;
      r_word       <= '0;
      r_partial    <= 1'b0;
      r_nib        <= '0;
      r_rd_pending <= 1'b0;
      r_flush_req  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_word       <= w_word_next;
      r_partial    <= w_partial_next;
      r_nib        <= w_nib_next;
      r_rd_pending <= w_rd_pending_next;
      r_flush_req  <= w_flush_next;
    end
  end

  // In-flight reads are counted so the word can never overfill.
  assign w_inflight = {1'b0, r_nib} + (CNT_W + 1)'(r_rd_pending);
  assign w_slot     = r_nib[SLOT_W-1:0];

  always_comb begin
    w_state_next   = r_state;
    w_word_next    = r_word;
    w_partial_next = r_partial;
    w_nib_next     = r_nib;
    w_flush_next   = r_flush_req;
    w_rd_en        = 1'b0;

    unique case (r_state)
      StFill: begin
        w_rd_en = ~fifo_empty & ~r_flush_req & (w_inflight < (CNT_W + 1)'(NIBBLES));
        if (flush) begin
          w_flush_next = 1'b1;
        end
        if (r_rd_pending) begin
          // First nibble of a new word clears stale slots so partial words pad with zero.
          if (r_nib == '0) begin
            w_word_next = '0;
          end
          w_word_next[w_slot*DATA_W +: DATA_W] = fifo_data;
          w_nib_next = r_nib + CNT_W'(1);
          if (w_nib_next == CNT_W'(NIBBLES)) begin
            w_state_next   = StHold;
            w_partial_next = 1'b0;
          end
        end else if (r_flush_req) begin
          w_flush_next = 1'b0;
          if (r_nib != '0) begin
            w_state_next   = StHold;
            w_partial_next = 1'b1;
          end
        end
      end
      StHold: begin
        if (word_ready) begin
          w_state_next   = StFill;
          w_nib_next     = '0;
          w_partial_next = 1'b0;
          w_flush_next   = 1'b0;
        end
      end
      default: w_state_next = StFill;
    endcase
  end

  assign w_rd_pending_next = w_rd_en & ~fifo_empty;

  assign fifo_rd_en   = w_rd_en;
  assign word_out     = r_word;
  assign word_valid   = (r_state == StHold);
  assign word_partial = r_partial;
  assign nib_count    = r_nib;

endmodule
